// File: rtl/wishbone_sram_responder.sv
// ---------------------------------------------------------------------------
// wishbone_sram_responder
// Wishbone B4 classic slave backed by an on-chip 16-bit word SRAM.
// It serves single accesses and held-CYC bursts, with programmable wait
// states, byte-lane writes and an address window decode.
//
// Optional feature macro: WB_SRAM_ERR_EN
//   defined   : out-of-window accesses are accepted and answered with wb_err
//   undefined : out-of-window accesses are ignored, and wb_err stays 0
//
// Parameters
//   ADDR_BITS    word address bits (depth = 2**ADDR_BITS), must be < 24
//   BASE_ADDR    window base; the low ADDR_BITS bits are ignored
//   WAIT_STATES  extra cycles before ACK/ERR, 0..15
//
// Ports
//   i_clk, i_rst  clock, synchronous active-high reset
//   wb_cyc/stb    bus cycle / transfer request
//   wb_adr        24-bit word address
//   wb_we         1 = write
//   wb_sel        byte lanes: [1]=dat[15:8], [0]=dat[7:0]
//   wb_i_dat      write data from master
//   wb_o_dat      read data, non-zero only in the ACK cycle
//   wb_ack        one-cycle transfer-done pulse
//   wb_err        one-cycle error pulse
//   wb_rty        tied 0
// ---------------------------------------------------------------------------
module wishbone_sram_responder #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic [23:0] wb_adr,
  input  logic        wb_we,
  input  logic [1:0]  wb_sel,
  input  logic [15:0] wb_i_dat,
  output logic [15:0] wb_o_dat,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        wb_rty
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DAT_W = 16;

`ifdef WB_SRAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic                 we_q, we_d;
  logic [1:0]           sel_q, sel_d;
  logic [DAT_W-1:0]     dat_q, dat_d;
  logic                 hit_q, hit_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [DAT_W-1:0]     rdat_q, rdat_d;

  logic                 hit_c;
  logic                 accept_c;
  logic                 wr_en_c;

  logic [DAT_W-1:0]     mem [DEPTH];

  // Window decode on the live address
  assign hit_c    = (wb_adr[23:ADDR_BITS] == BASE_ADDR[23:ADDR_BITS]);
  assign accept_c = wb_cyc & wb_stb & (hit_c | ERR_EN);

  // Next-state, latch and registered-output logic. The *_d latch values
  // describe the transfer in flight, so the edge entering RESP works the
  // same whether it comes from IDLE (zero wait states) or from WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    hit_d   = hit_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdat_d  = '0;
    wr_en_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          idx_d   = wb_adr[ADDR_BITS-1:0];
          we_d    = wb_we;
          sel_d   = wb_sel;
          dat_d   = wb_i_dat;
          hit_d   = hit_c;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wb_cyc) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Response values are registered on the edge that enters RESP
    if (state_d == S_RESP) begin
      if (hit_d) begin
        ack_d = 1'b1;
        if (we_d) begin
          wr_en_c = 1'b1;
        end else begin
          rdat_d = mem[idx_d];
        end
      end else begin
        err_d = ERR_EN;
      end
    end
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      hit_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      hit_q   <= hit_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  // SRAM write port; contents are not reset, but reset blocks a pending write
  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_en_c) begin
      if (sel_d[0]) mem[idx_d][7:0]  <= dat_d[7:0];
      if (sel_d[1]) mem[idx_d][15:8] <= dat_d[15:8];
    end
  end

  assign wb_o_dat = rdat_q;
  assign wb_ack   = ack_q;
  assign wb_err   = err_q;
  assign wb_rty   = 1'b0;

endmodule

// File: tb/tb_wishbone_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_wishbone_sram_responder
// Directed bench for wishbone_sram_responder. There are two instances:
// u_ws1 has WAIT_STATES=1 and u_ws3 has WAIT_STATES=3. The two instances
// share one bus, and use3 selects which instance receives CYC/STB.
// The bench drives and samples on the falling edge.
// ---------------------------------------------------------------------------
module tb_wishbone_sram_responder;

  logic        clk;
  logic        rst;
  logic        cyc, stb, we, use3;
  logic [23:0] adr;
  logic [1:0]  sel;
  logic [15:0] dat;

  logic [15:0] odat_a, odat_b, odat;
  logic        ack_a, ack_b, ack;
  logic        err_a, err_b, err;
  logic        rty_a, rty_b;

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wishbone_sram_responder #(
    .ADDR_BITS(10), .BASE_ADDR(24'h000000), .WAIT_STATES(1)
  ) u_ws1 (
    .i_clk(clk), .i_rst(rst),
    .wb_cyc(cyc & ~use3), .wb_stb(stb & ~use3),
    .wb_adr(adr), .wb_we(we), .wb_sel(sel), .wb_i_dat(dat),
    .wb_o_dat(odat_a), .wb_ack(ack_a), .wb_err(err_a), .wb_rty(rty_a)
  );

  wishbone_sram_responder #(
    .ADDR_BITS(10), .BASE_ADDR(24'h000000), .WAIT_STATES(3)
  ) u_ws3 (
    .i_clk(clk), .i_rst(rst),
    .wb_cyc(cyc & use3), .wb_stb(stb & use3),
    .wb_adr(adr), .wb_we(we), .wb_sel(sel), .wb_i_dat(dat),
    .wb_o_dat(odat_b), .wb_ack(ack_b), .wb_err(err_b), .wb_rty(rty_b)
  );

  assign odat = use3 ? odat_b : odat_a;
  assign ack  = use3 ? ack_b  : ack_a;
  assign err  = use3 ? err_b  : err_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One transfer. lat is the number of cycles from the STB edge until ACK
  // or ERR is seen, or 0 if nothing is seen within 20 cycles.
  task automatic xfer(input logic w, input logic [23:0] a, input logic [1:0] s,
                      input logic [15:0] d, output int lat, output logic [15:0] rd,
                      output logic ak, output logic er);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
    lat = 0; rd = '0; ak = 1'b0; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack || err) begin
        lat = i; rd = odat; ak = ack; er = err;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // The cycle after a response must be quiet
  task automatic post_chk(input string tag);
    @(negedge clk);
    chk({tag, "_ack_low"}, 32'(ack), 32'h0);
    chk({tag, "_dat_zero"}, 32'(odat), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          cnt;
    int          bt[3];
    logic [15:0] bd[3];
    logic [15:0] rd;
    logic        ak, er;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; use3 = 1'b0;
    adr = '0; sel = '0; dat = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Check the reset state
    chk("rst_ack_ws1", 32'(ack_a), 32'h0);
    chk("rst_err_ws1", 32'(err_a), 32'h0);
    chk("rst_dat_ws1", 32'(odat_a), 32'h0);
    chk("rst_ack_ws3", 32'(ack_b), 32'h0);
    chk("rty_tied", 32'({rty_a, rty_b}), 32'h0);

    // Test 1: write, then read, with one wait state
    xfer(1'b1, 24'h000005, 2'b11, 16'hBEEF, lat, rd, ak, er);
    chk("t1_wr_lat", 32'(lat), 32'd2);
    post_chk("t1_wr");
    xfer(1'b0, 24'h000005, 2'b11, 16'h0000, lat, rd, ak, er);
    chk("t1_rd_lat", 32'(lat), 32'd2);
    chk("t1_rd_dat", 32'(rd), 32'hBEEF);
    post_chk("t1_rd");

    // Test 2: byte-lane writes
    xfer(1'b1, 24'h000005, 2'b01, 16'h1234, lat, rd, ak, er);
    xfer(1'b0, 24'h000005, 2'b11, 16'h0000, lat, rd, ak, er);
    chk("t2_lo_dat", 32'(rd), 32'hBE34);
    xfer(1'b1, 24'h000005, 2'b10, 16'h5600, lat, rd, ak, er);
    xfer(1'b0, 24'h000005, 2'b11, 16'h0000, lat, rd, ak, er);
    chk("t2_hi_dat", 32'(rd), 32'h5634);
    xfer(1'b1, 24'h000005, 2'b00, 16'hFFFF, lat, rd, ak, er);
    chk("t2_sel0_lat", 32'(lat), 32'd2);
    xfer(1'b0, 24'h000005, 2'b11, 16'h0000, lat, rd, ak, er);
    chk("t2_sel0_dat", 32'(rd), 32'h5634);

    // Test 3: a burst with CYC/STB held, where ADR advances on each ACK
    xfer(1'b1, 24'h000010, 2'b11, 16'h1010, lat, rd, ak, er);
    xfer(1'b1, 24'h000011, 2'b11, 16'h2121, lat, rd, ak, er);
    xfer(1'b1, 24'h000012, 2'b11, 16'h3232, lat, rd, ak, er);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 2'b11; adr = 24'h000010;
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack) begin
        bt[cnt] = i; bd[cnt] = odat; cnt++;
        if (cnt == 3) break;
        adr = 24'h000010 + 24'(cnt);
      end
    end
    cyc = 1'b0; stb = 1'b0;
    chk("t3_beats", 32'(cnt), 32'd3);
    chk("t3_t0", 32'(bt[0]), 32'd2);
    chk("t3_t1", 32'(bt[1]), 32'd5);
    chk("t3_t2", 32'(bt[2]), 32'd8);
    chk("t3_d0", 32'(bd[0]), 32'h1010);
    chk("t3_d1", 32'(bd[1]), 32'h2121);
    chk("t3_d2", 32'(bd[2]), 32'h3232);

    // STB without CYC must be ignored
    @(negedge clk);
    stb = 1'b1; cyc = 1'b0; adr = 24'h000005;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack || err) cnt++;
    end
    stb = 1'b0;
    chk("stb_no_cyc", 32'(cnt), 32'd0);

    // Test 4: three wait states, with CYC dropped during WAIT
    use3 = 1'b1;
    xfer(1'b1, 24'h000007, 2'b11, 16'h5555, lat, rd, ak, er);
    chk("t4_wr_lat", 32'(lat), 32'd4);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 24'h000007; dat = 16'hAAAA; sel = 2'b11;
    repeat (2) @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack || err) cnt++;
    end
    chk("t4_abort_noack", 32'(cnt), 32'd0);
    xfer(1'b0, 24'h000007, 2'b11, 16'h0000, lat, rd, ak, er);
    chk("t4_rd_lat", 32'(lat), 32'd4);
    chk("t4_rd_dat", 32'(rd), 32'h5555);

    // ADR and DAT changes during WAIT must be ignored
    xfer(1'b1, 24'h000009, 2'b11, 16'h9999, lat, rd, ak, er);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 24'h000008; dat = 16'h1111; sel = 2'b11;
    @(negedge clk);
    adr = 24'h000009; dat = 16'h2222;
    lat = 0;
    for (int i = 2; i <= 20; i++) begin
      @(negedge clk);
      if (ack) begin lat = i; break; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("hold_lat", 32'(lat), 32'd4);
    xfer(1'b0, 24'h000008, 2'b11, 16'h0000, lat, rd, ak, er);
    chk("hold_adr8", 32'(rd), 32'h1111);
    xfer(1'b0, 24'h000009, 2'b11, 16'h0000, lat, rd, ak, er);
    chk("hold_adr9", 32'(rd), 32'h9999);

    // Reset on the edge that would enter RESP: no write and no ACK
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 24'h000007; dat = 16'hAAAA; sel = 2'b11;
    repeat (3) @(negedge clk);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_ack", 32'(ack), 32'h0);
    xfer(1'b0, 24'h000007, 2'b11, 16'h0000, lat, rd, ak, er);
    chk("rstw_dat", 32'(rd), 32'h5555);
    use3 = 1'b0;

    // Test 5: an out-of-window access
    xfer(1'b1, 24'h000000, 2'b11, 16'h0F0F, lat, rd, ak, er);
    xfer(1'b1, 24'h000400, 2'b11, 16'hDEAD, lat, rd, ak, er);
`ifdef WB_SRAM_ERR_EN
    chk("t5_wr_err_lat", 32'(lat), 32'd2);
    chk("t5_wr_err", 32'({ak, er}), 32'h1);
`else
    chk("t5_wr_noresp", 32'(lat), 32'd0);
`endif
    xfer(1'b0, 24'h000400, 2'b11, 16'h0000, lat, rd, ak, er);
`ifdef WB_SRAM_ERR_EN
    chk("t5_rd_err_lat", 32'(lat), 32'd2);
    chk("t5_rd_err", 32'({ak, er}), 32'h1);
    chk("t5_rd_dat", 32'(rd), 32'h0);
`else
    chk("t5_rd_noresp", 32'(lat), 32'd0);
`endif
    xfer(1'b0, 24'h000000, 2'b11, 16'h0000, lat, rd, ak, er);
    chk("t5_alias_dat", 32'(rd), 32'h0F0F);

    // Test 6: reset while in RESP
    xfer(1'b0, 24'h000005, 2'b11, 16'h0000, lat, rd, ak, er);
    chk("t6_rd_dat", 32'(rd), 32'h5634);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_ack", 32'(ack), 32'h0);
    chk("t6_err", 32'(err), 32'h0);
    chk("t6_dat", 32'(odat), 32'h0);
    rst = 1'b0;
    xfer(1'b0, 24'h000005, 2'b11, 16'h0000, lat, rd, ak, er);
    chk("t6_after_lat", 32'(lat), 32'd2);
    chk("t6_mem_kept", 32'(rd), 32'h5634);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
